rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file (array of register32 instances) among NREQ requesters.
- Round-robin arbitration, with an optional per-requester lock for back-to-back bursts.
- Produces a registered one-hot write-enable vector, plus data and address, that drive the register wEnable/in inputs directly.
- Writes to register 0 and to out-of-range addresses are accepted and discarded.

Parameters:
- NREQ, 3, number of requesters (2..8)
- NREGS, 32, number of registers; width of rf_wen
- AW, 5, address width; 2^AW >= NREGS
- DW, 32, data width
- LOCK_MAX, 8, maximum consecutive cycles a lock may be held before forced release (>=1)

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester write request
- req_lock  in  NREQ  requester wants to keep the grant after this beat
- req_addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  flattened data; requester i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot or zero; beat i accepted when req_valid[i] & req_ready[i]
- rf_wen  out  NREGS  registered one-hot register write enable
- rf_waddr  out  AW  registered address of the last accepted beat
- rf_wdata  out  DW  registered data of the last accepted beat
- wr_valid  out  1  registered; 1 when rf_wen carries a real write
- grant_id  out  clog2(NREQ)  registered index of the last accepted requester
- locked  out  1  registered; 1 while state is LOCKED

Behaviour:
- Reset (clr high, asynchronous): rf_wen=0, rf_waddr=0, rf_wdata=0, wr_valid=0, grant_id=0, locked=0, rr pointer=0, state=ARB, lock counter=0. req_ready is 0 while clr is high.
- req_ready is combinational from req_valid, state, pointer and owner. It is never high for a requester whose req_valid is low. At most one bit is set.
- State ARB:
  - Winner is the first valid requester scanning from the pointer upward, modulo NREQ.
  - On accept of i with req_lock[i]=0: pointer <= (i+1) mod NREQ.
  - On accept of i with req_lock[i]=1: state <= LOCKED, owner <= i, counter <= 1. The pointer is unchanged.
- State LOCKED:
  - Only the owner may be granted. Other requesters get req_ready=0 even if the owner is idle.
  - counter increments every cycle in LOCKED, whether or not a beat is accepted.
  - Owner beat accepted with req_lock=0: state <= ARB, pointer <= (owner+1) mod NREQ. This beat is still written.
  - counter reaches LOCK_MAX: forced release on that edge. state <= ARB, pointer <= (owner+1) mod NREQ. A beat accepted on that same edge is still written.
  - Releasing beat and timeout on the same edge: a single release.
- Write stage, the edge after an accept of beat (a, d) from i:
  - rf_waddr=a, rf_wdata=d, grant_id=i.
  - If 0 < a < NREGS: rf_wen = 1<<a and wr_valid=1.
  - Else (a=0 or a>=NREGS): rf_wen=0 and wr_valid=0. The beat is dropped silently.
- Cycle with no accept: next edge rf_wen=0 and wr_valid=0. rf_waddr, rf_wdata and grant_id hold.
- Latency: request accepted in cycle N, register file sees wEnable during cycle N+1 and captures on the N+2 edge. Throughput is 1 beat/cycle.
- rf_wen is held for exactly one cycle per beat. Consecutive beats to the same address give rf_wen high for consecutive cycles.
- clr asserted mid-burst: LOCKED is abandoned and any in-flight output write is cancelled (rf_wen=0 immediately).
- Unused requesters (valid held low) are skipped at no cycle cost.

Test Plan:
- Reset/idle: hold clr 3 cycles, then release with req_valid=0 -> all outputs 0, req_ready=0, locked=0 throughout.
- Single write: req0 valid, addr=5, data=0xDEADBEEF, 1 cycle -> req_ready[0]=1 that cycle. Next cycle rf_wen=0x00000020, rf_wdata=0xDEADBEEF, wr_valid=1, grant_id=0. Following cycle rf_wen=0.
- Round-robin: all 3 requesters valid continuously with addrs 1/2/3, no lock -> grant order 0,1,2,0,1,2. rf_wen sequence 0x2,0x4,0x8 repeating, one per cycle.
- Lock burst:
  - req1 sends 4 beats with lock=1,1,1,0 while req0 and req2 stay valid -> only req1 granted, locked=1 for 3 cycles.
  - Next grant goes to req2.
- Lock timeout: LOCK_MAX=8; req2 locks then drops valid -> no grants for the 7 following cycles, forced release on cycle 8, req0 granted next, locked falls to 0.
- Discarded writes and async reset:
  - Beat to addr 0 -> req_ready=1, next cycle wr_valid=0, rf_wen=0.
  - Beat to addr 7, then clr pulsed mid-cycle right after the accept edge -> rf_wen drops to 0 asynchronously, and state=ARB after release.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Write-port bus between the register-file requesters and rf_write_arbiter.
// Requesters drive the master side. The arbiter is the slave and returns ready plus the registered write stage.
interface rf_write_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  logic [NREGS-1:0]   rf_wen;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic               wr_valid;
  logic [IDW-1:0]     grant_id;
  logic               locked;

  modport master (
    output req_valid, req_lock, req_addr, req_data,
    input  req_ready, rf_wen, rf_waddr, rf_wdata, wr_valid, grant_id, locked
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data,
    output req_ready, rf_wen, rf_waddr, rf_wdata, wr_valid, grant_id, locked
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter with optional burst lock for the shared register-file write port.
// Each accepted beat becomes a one-cycle one-hot wEnable on the following cycle. Beats to register 0 or out of range are dropped.
module rf_write_arbiter #(
  parameter int NREQ     = 3,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input logic clk,
  input logic clr,
  rf_write_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(LOCK_MAX + 2);

  typedef enum logic {
    ST_ARB,
    ST_LOCKED
  } state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [IDW-1:0]  owner, owner_nxt;
  logic [CW-1:0]   lock_cnt, cnt_nxt;

  logic            win_found;
  logic [IDW-1:0]  win_idx;
  logic [IDW-1:0]  acc_idx;
  logic [NREQ-1:0] ready;
  logic            accept;
  logic            acc_lock;
  logic [AW-1:0]   acc_addr;
  logic [DW-1:0]   acc_data;
  logic            in_range;
  logic            timeout;

  function automatic logic [IDW-1:0] next_of(input logic [IDW-1:0] i);
    if (32'(i) == NREQ - 1)
      return '0;
    return i + IDW'(1);
  endfunction

  // First valid requester at or after the pointer, wrapping modulo NREQ
  always_comb begin
    logic [IDW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (!clr) begin
      if (state == ST_ARB) begin
        if (win_found)
          ready[win_idx] = 1'b1;
      end else begin
        ready[owner] = bus.req_valid[owner];
      end
    end
  end

  assign bus.req_ready = ready;
  assign accept    = |ready;
  assign acc_idx   = (state == ST_ARB) ? win_idx : owner;
  assign acc_lock  = bus.req_lock[acc_idx];
  assign acc_addr  = bus.req_addr[32'(acc_idx)*AW +: AW];
  assign acc_data  = bus.req_data[32'(acc_idx)*DW +: DW];
  assign in_range  = (acc_addr != '0) && (32'(acc_addr) < NREGS);
  // The counter starts at 1 on the locking beat, so the lock spans LOCK_MAX cycles including that beat
  assign timeout   = (32'(lock_cnt) + 1 >= LOCK_MAX);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    cnt_nxt   = lock_cnt;
    case (state)
      ST_ARB: begin
        if (accept) begin
          if (acc_lock) begin
            state_nxt = ST_LOCKED;
            owner_nxt = acc_idx;
            cnt_nxt   = CW'(1);
          end else begin
            ptr_nxt = next_of(acc_idx);
          end
        end
      end
      ST_LOCKED: begin
        cnt_nxt = lock_cnt + CW'(1);
        if ((accept && !acc_lock) || timeout) begin
          state_nxt = ST_ARB;
          ptr_nxt   = next_of(owner);
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_ARB;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_ARB;
      ptr      <= '0;
      owner    <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      lock_cnt <= cnt_nxt;
    end
  end

  // Address, data and id hold across idle cycles. The enable is a single-cycle pulse per beat
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bus.rf_wen   <= '0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.wr_valid <= 1'b0;
      bus.grant_id <= '0;
      bus.locked   <= 1'b0;
    end else begin
      bus.rf_wen   <= '0;
      bus.wr_valid <= 1'b0;
      bus.locked   <= (state_nxt == ST_LOCKED);
      if (accept) begin
        bus.rf_waddr <= acc_addr;
        bus.rf_wdata <= acc_data;
        bus.grant_id <= acc_idx;
        if (in_range) begin
          bus.rf_wen   <= NREGS'(1) << acc_addr;
          bus.wr_valid <= 1'b1;
        end
      end
    end
  end
endmodule
